// File: rtl/debouncer_array.sv
// debouncer_array: N_CH independent push-button conditioners (sync, polarity, bounce filter, edge/hold pulses).
// Latency: a stable input change shows on level after 2 + DEBOUNCE_CYCLES clock edges.
// No backpressure: pure per-channel pipeline, all outputs registered and glitch-free.
module debouncer_array #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 1500000,
  parameter int HOLD_CYCLES     = 0,
  parameter int MODE            = 1,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] hold_pulse,
  output logic [N_CH-1:0] busy
);

  // One counter width serves both the debounce and the hold counter.
  localparam int MAX_CYC = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
  localparam logic          IDLE_RAW = (ACTIVE_LOW != 0);
  localparam logic          STABLE   = (MODE == 1);

  typedef enum logic [1:0] {
    S_LOW        = 2'd0,
    S_DELAY_RISE = 2'd1,
    S_HIGH       = 2'd2,
    S_DELAY_FALL = 2'd3
  } state_t;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic          r_sync1;
    logic          r_sync2;
    logic          w_s;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_hold_cnt;
    logic          r_level;
    logic          r_busy;
    logic          r_press;
    logic          r_release;
    logic          r_hold;

    // Two-flop synchroniser; resets to the idle raw level so reset release never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync1 <= IDLE_RAW;
        r_sync2 <= IDLE_RAW;
      end else begin
        r_sync1 <= din[g];
        r_sync2 <= r_sync1;
      end
    end

    // Pressed-is-one view of the synchronised input.
    assign w_s = r_sync2 ^ IDLE_RAW;

    // Debounce FSM with its delay and hold counters; outputs are registered alongside each transition.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state    <= S_LOW;
        r_cnt      <= '0;
        r_hold_cnt <= '0;
        r_level    <= 1'b0;
        r_busy     <= 1'b0;
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_hold     <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_hold    <= 1'b0;
        case (r_state)
          S_LOW: begin
            if (w_s) begin
              r_state <= S_DELAY_RISE;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
          S_DELAY_RISE: begin
            if (STABLE && !w_s) begin
              // Bounce inside the window: silently fall back.
              r_state <= S_LOW;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end else if (r_cnt == DEB_LAST) begin
              r_state    <= S_HIGH;
              r_hold_cnt <= '0;
              r_level    <= 1'b1;
              r_busy     <= 1'b0;
              r_press    <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_HIGH: begin
            if (!w_s) begin
              r_state <= S_DELAY_FALL;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end else if (r_hold_cnt != HOLD_MAX) begin
              // Saturating count: the pulse fires only on the step that reaches HOLD_MAX.
              r_hold_cnt <= r_hold_cnt + 1'b1;
              if (r_hold_cnt == HOLD_MAX - 1'b1) begin
                r_hold <= 1'b1;
              end
            end
          end
          S_DELAY_FALL: begin
            if (STABLE && w_s) begin
              // Release bounce: resume the same press; hold_cnt is kept so hold cannot re-fire.
              r_state <= S_HIGH;
              r_busy  <= 1'b0;
            end else if (r_cnt == DEB_LAST) begin
              r_state   <= S_LOW;
              r_level   <= 1'b0;
              r_busy    <= 1'b0;
              r_release <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_LOW;
            r_level <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end

    assign level[g]         = r_level;
    assign busy[g]          = r_busy;
    assign press_pulse[g]   = r_press;
    assign release_pulse[g] = r_release;
    assign hold_pulse[g]    = r_hold;
  end

endmodule

// File: tb/tb_debouncer_array.sv
// Bench for debouncer_array: three configurations run side by side against a timestamp-based model.
// Directed scenarios pin exact edges with literal values; a random phase exercises bounce and reset.
// Inputs change 2 time units after a rising edge; outputs are compared on the falling edge.
module tb_debouncer_array;

  localparam int NC = 4;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ND-1:0][NC-1:0] raw;
  logic [ND-1:0][NC-1:0] o_level, o_busy, o_press, o_release, o_hold;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Config 0: stable window, long-press enabled.
  debouncer_array #(.N_CH(NC), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .MODE(1), .ACTIVE_LOW(0)) u_dut0 (
    .clk(clk), .rst(rst), .din(raw[0]), .level(o_level[0]), .press_pulse(o_press[0]),
    .release_pulse(o_release[0]), .hold_pulse(o_hold[0]), .busy(o_busy[0]));
  // Config 1: fixed delay, active-low inputs, no long-press.
  debouncer_array #(.N_CH(NC), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(0), .MODE(0), .ACTIVE_LOW(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(raw[1]), .level(o_level[1]), .press_pulse(o_press[1]),
    .release_pulse(o_release[1]), .hold_pulse(o_hold[1]), .busy(o_busy[1]));
  // Config 2: one-cycle delay states, short hold.
  debouncer_array #(.N_CH(NC), .DEBOUNCE_CYCLES(1), .HOLD_CYCLES(3), .MODE(1), .ACTIVE_LOW(0)) u_dut2 (
    .clk(clk), .rst(rst), .din(raw[2]), .level(o_level[2]), .press_pulse(o_press[2]),
    .release_pulse(o_release[2]), .hold_pulse(o_hold[2]), .busy(o_busy[2]));

  function automatic int p_deb(int d);
    case (d) 0: return 4; 1: return 4; default: return 1; endcase
  endfunction
  function automatic int p_hold(int d);
    case (d) 0: return 10; 1: return 0; default: return 3; endcase
  endfunction
  function automatic int p_mode(int d);
    case (d) 0: return 1; 1: return 0; default: return 1; endcase
  endfunction
  function automatic int p_al(int d);
    case (d) 1: return 1; default: return 0; endcase
  endfunction

  task automatic chk(input string nm, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_n(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic lit1(input string nm, input logic act, input logic exp);
    chk(nm, {3'b000, act}, {3'b000, exp});
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is described by its current clean level, whether a change is pending
  // and the edge number at which that pending change began; the change lands D edges later.
  logic [ND-1:0][NC-1:0] m_lvl, m_pend, m_s1, m_s2;
  int m_start [ND][NC];
  int m_hold  [ND][NC];
  logic [ND-1:0][NC-1:0] e_level, e_busy, e_press, e_release, e_hold;
  int k = 0;

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NC; c++) begin
        m_lvl[d][c]   = 1'b0;
        m_pend[d][c]  = 1'b0;
        m_start[d][c] = 0;
        m_hold[d][c]  = 0;
        m_s1[d][c]    = (p_al(d) != 0);
        m_s2[d][c]    = (p_al(d) != 0);
      end
    end
    e_level = '0; e_busy = '0; e_press = '0; e_release = '0; e_hold = '0;
  endtask

  task automatic model_step();
    logic s;
    k++;
    e_press = '0; e_release = '0; e_hold = '0;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NC; c++) begin
        s = m_s2[d][c] ^ (p_al(d) != 0);
        m_s2[d][c] = m_s1[d][c];
        m_s1[d][c] = raw[d][c];
        if (!m_pend[d][c]) begin
          if (s != m_lvl[d][c]) begin
            m_pend[d][c]  = 1'b1;
            m_start[d][c] = k;
          end else if (m_lvl[d][c] && m_hold[d][c] < p_hold(d)) begin
            m_hold[d][c]++;
            if (m_hold[d][c] == p_hold(d)) e_hold[d][c] = 1'b1;
          end
        end else if (p_mode(d) == 1 && s == m_lvl[d][c]) begin
          m_pend[d][c] = 1'b0;
        end else if (k - m_start[d][c] == p_deb(d)) begin
          m_pend[d][c] = 1'b0;
          m_lvl[d][c]  = ~m_lvl[d][c];
          if (m_lvl[d][c]) begin
            e_press[d][c] = 1'b1;
            m_hold[d][c]  = 0;
          end else begin
            e_release[d][c] = 1'b1;
          end
        end
        e_level[d][c] = m_lvl[d][c];
        e_busy[d][c]  = m_pend[d][c];
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("dut%0d level", d),   o_level[d],   e_level[d]);
        chk($sformatf("dut%0d busy", d),    o_busy[d],    e_busy[d]);
        chk($sformatf("dut%0d press", d),   o_press[d],   e_press[d]);
        chk($sformatf("dut%0d release", d), o_release[d], e_release[d]);
        chk($sformatf("dut%0d hold", d),    o_hold[d],    e_hold[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pc, hc, rc, pe, he, seen, bad, rate;
    raw[0] = 4'b0000;
    raw[1] = 4'b1111;
    raw[2] = 4'b0000;
    rst    = 1'b1;
    repeat (3) tick();
    chk("reset level dut0", o_level[0], 4'b0000);
    chk("reset busy dut0",  o_busy[0],  4'b0000);
    chk("reset press dut1", o_press[1], 4'b0000);
    rst = 1'b0;
    repeat (6) tick();
    chk("active-low idle press", o_press[1], 4'b0000);
    chk("active-low idle level", o_level[1], 4'b0000);

    // Clean press and release on dut0 ch0.
    raw[0][0] = 1'b1;
    tick(); tick();
    lit1("clean busy e1", o_busy[0][0], 1'b0);
    tick();
    lit1("clean busy e2", o_busy[0][0], 1'b1);
    lit1("model busy e2", e_busy[0][0], 1'b1);
    repeat (3) tick();
    lit1("clean level e5", o_level[0][0], 1'b0);
    tick();
    lit1("clean level e6", o_level[0][0], 1'b1);
    lit1("clean press e6", o_press[0][0], 1'b1);
    lit1("model press e6", e_press[0][0], 1'b1);
    lit1("clean busy e6",  o_busy[0][0],  1'b0);
    tick();
    lit1("clean press e7", o_press[0][0], 1'b0);
    repeat (8) tick();
    lit1("hold e15", o_hold[0][0], 1'b0);
    tick();
    lit1("hold e16", o_hold[0][0], 1'b1);
    lit1("model hold e16", e_hold[0][0], 1'b1);
    tick();
    lit1("hold e17", o_hold[0][0], 1'b0);
    repeat (8) tick();
    raw[0][0] = 1'b0;
    repeat (6) tick();
    lit1("release r5 level", o_level[0][0], 1'b1);
    lit1("release r5 pulse", o_release[0][0], 1'b0);
    tick();
    lit1("release r6 pulse", o_release[0][0], 1'b1);
    lit1("release r6 level", o_level[0][0], 1'b0);
    tick();
    lit1("release r7 pulse", o_release[0][0], 1'b0);

    // Stable-window bounce on dut0 ch2: two high cycles then low.
    raw[0][2] = 1'b1;
    tick(); tick();
    raw[0][2] = 1'b0;
    seen = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_busy[0][2]) seen = 1;
      if (o_level[0][2] || o_press[0][2] || o_release[0][2]) bad++;
    end
    chk_n("bounce busy seen", seen, 1);
    chk_n("bounce no output", bad, 0);
    lit1("bounce busy end", o_busy[0][2], 1'b0);

    // Same bounce in fixed-delay mode (dut1 ch0, active low).
    raw[1][0] = 1'b0;
    tick(); tick();
    raw[1][0] = 1'b1;
    repeat (4) tick();
    lit1("fixed press e5", o_press[1][0], 1'b0);
    tick();
    lit1("fixed press e6", o_press[1][0], 1'b1);
    lit1("fixed level e6", o_level[1][0], 1'b1);
    repeat (4) tick();
    lit1("fixed release e10", o_release[1][0], 1'b0);
    lit1("fixed busy e10",    o_busy[1][0],    1'b1);
    tick();
    lit1("fixed release e11", o_release[1][0], 1'b1);
    lit1("fixed level e11",   o_level[1][0],   1'b0);

    // Long press on dut0 ch1, then a release bounce that must not re-trigger anything.
    raw[0][1] = 1'b1;
    pc = 0; hc = 0; pe = -1; he = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_press[0][1]) begin pc++; pe = i; end
      if (o_hold[0][1])  begin hc++; he = i; end
    end
    chk_n("long press count", pc, 1);
    chk_n("long press edge", pe, 6);
    chk_n("long hold count", hc, 1);
    chk_n("long hold offset", he - pe, 10);
    raw[0][1] = 1'b0;
    tick(); tick();
    raw[0][1] = 1'b1;
    pc = 0; hc = 0; rc = 0; seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_press[0][1])   pc++;
      if (o_hold[0][1])    hc++;
      if (o_release[0][1]) rc++;
      if (o_busy[0][1])    seen = 1;
    end
    chk_n("abort busy seen", seen, 1);
    chk_n("abort no press", pc, 0);
    chk_n("abort no hold", hc, 0);
    chk_n("abort no release", rc, 0);
    lit1("abort level kept", o_level[0][1], 1'b1);

    // Active-low multi-channel press and independent releases (dut1).
    raw[1] = 4'b1010;
    repeat (6) tick();
    chk("al press e5", o_press[1], 4'b0000);
    tick();
    chk("al press e6", o_press[1], 4'b0101);
    repeat (5) tick();
    raw[1][0] = 1'b1;
    tick();
    raw[1][2] = 1'b1;
    repeat (5) tick();
    chk("al release r5", o_release[1], 4'b0000);
    tick();
    chk("al release r6", o_release[1], 4'b0001);
    tick();
    chk("al release r7", o_release[1], 4'b0100);

    // Reset while dut0 ch0 is debouncing a rise and ch1 is held high.
    raw[0][0] = 1'b1;
    repeat (3) tick();
    lit1("pre-rst ch0 busy",  o_busy[0][0],  1'b1);
    lit1("pre-rst ch1 level", o_level[0][1], 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst async level", o_level[0], 4'b0000);
    chk("rst async busy",  o_busy[0],  4'b0000);
    chk("rst model level", e_level[0], 4'b0000);
    tick(); tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("redebounce press e5", o_press[0], 4'b0000);
    tick();
    chk("redebounce press e6", o_press[0], 4'b0011);

    // Random phase: varying bounce rates and occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      case ((i / 400) % 3)
        0:       rate = 2;
        1:       rate = 12;
        default: rate = 30;
      endcase
      for (int d = 0; d < ND; d++) begin
        for (int c = 0; c < NC; c++) begin
          if ($urandom_range(0, rate) == 0) raw[d][c] = ~raw[d][c];
        end
      end
      if ($urandom_range(0, 699) == 0) begin
        #1 rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    raw[0] = 4'b0000;
    raw[1] = 4'b1111;
    raw[2] = 4'b0000;
    repeat (20) tick();
    chk("final level dut0", o_level[0], 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
